// File: rtl/idecode_stage.sv
// RV32I/RV64I decode stage: combinational field/immediate decode registered behind a
// valid/ready handshake, with an optional 2-entry skid so in_ready comes straight from a flop.
module idecode_stage #(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3, F_U = 3'd4, F_J = 3'd5, F_ILL = 3'd7
  } fmt_e;

  // Raw word is kept so field outputs pass through even for illegal encodings.
  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [31:0]     instr;
    fmt_e            fmt;
  } dec_t;

  logic [6:0]         op, f7;
  logic [2:0]         f3;
  logic               bad;
  fmt_e               fmt;
  logic signed [31:0] raw;
  dec_t               dec;

  assign op = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];

  always_comb begin
    fmt = F_ILL;
    bad = 1'b0;
    raw = '0;
    case (op)
      OP_LUI, OP_AUIPC: fmt = F_U;
      OP_JAL:           fmt = F_J;
      OP_MISC, OP_SYS:  fmt = F_I;
      OP_JALR: begin fmt = F_I; bad = (f3 != 3'b000); end
      OP_LOAD: begin
        fmt = F_I;
        bad = (f3 == 3'b111) || (XLEN == 32 && (f3 == 3'b011 || f3 == 3'b110));
      end
      OP_IMM: begin
        fmt = F_I;
        if (f3 == 3'b001) bad = (in_instr[31:26] != 6'b000000);
        if (f3 == 3'b101) bad = (in_instr[31:26] != 6'b000000) && (in_instr[31:26] != 6'b010000);
        // shamt[5] only exists on RV64
        if (XLEN == 32 && f3[1:0] == 2'b01 && in_instr[25]) bad = 1'b1;
      end
      OP_STORE:  begin fmt = F_S; bad = f3[2] || (XLEN == 32 && f3 == 3'b011); end
      OP_BRANCH: begin fmt = F_B; bad = (f3[2:1] == 2'b01); end
      OP_OP: begin
        fmt = F_R;
        bad = !((f7 == 7'b0000000) || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      default: fmt = F_ILL;
    endcase
    if (bad) fmt = F_ILL;
    case (fmt)
      F_U:     raw = {in_instr[31:12], 12'b0};
      F_J:     raw = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      F_I:     raw = {{20{in_instr[31]}}, in_instr[31:20]};
      F_S:     raw = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      F_B:     raw = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      default: raw = '0;
    endcase
    dec.imm   = XLEN'(raw);
    dec.instr = in_instr;
    dec.fmt   = fmt;
  end

  dec_t out_q, out_d, skid_q, skid_d;
  logic out_vld_q, out_vld_d, skid_full_q, skid_full_d, rdy_q;
  logic in_xfer, out_xfer;

  assign in_ready = (SKID != 0) ? rdy_q : (!out_vld_q || out_ready);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_vld_q && out_ready;

  always_comb begin
    out_d       = out_q;
    out_vld_d   = out_vld_q;
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
    if (SKID != 0) begin
      if (!out_vld_q || out_xfer) begin
        if (skid_full_q) begin
          out_d       = skid_q;
          out_vld_d   = 1'b1;
          skid_full_d = 1'b0;
        end else if (in_xfer) begin
          out_d     = dec;
          out_vld_d = 1'b1;
        end else begin
          out_vld_d = 1'b0;
        end
      end else if (in_xfer) begin
        skid_d      = dec;
        skid_full_d = 1'b1;
      end
    end else begin
      if (in_xfer) begin
        out_d     = dec;
        out_vld_d = 1'b1;
      end else if (out_xfer) begin
        out_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      skid_q      <= '0;
      out_vld_q   <= 1'b0;
      skid_full_q <= 1'b0;
      rdy_q       <= 1'b1;
    end else begin
      out_q       <= out_d;
      skid_q      <= skid_d;
      out_vld_q   <= out_vld_d;
      skid_full_q <= skid_full_d;
      rdy_q       <= !skid_full_d;
    end
  end

  assign out_valid   = out_vld_q;
  assign out_imm     = out_q.imm;
  assign out_rs1     = out_q.instr[19:15];
  assign out_rs2     = out_q.instr[24:20];
  assign out_rd      = out_q.instr[11:7];
  assign out_opcode  = out_q.instr[6:0];
  assign out_funct3  = out_q.instr[14:12];
  assign out_funct7  = out_q.instr[31:25];
  assign out_fmt     = out_q.fmt;
  assign out_illegal = (out_q.fmt == F_ILL);
endmodule

// File: tb/tb_idecode_stage.sv
// Bench for idecode_stage: three instances (RV32 skid, RV64 skid, RV32 no-skid) share stimulus;
// a queue-based reference model is checked every falling edge, plus literal pins.
module tb_idecode_stage;
  typedef struct packed {
    logic [63:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] in_instr = '0;
  logic [2:0] ir, ov, ill;
  logic [2:0][4:0] rs1, rs2, rd;
  logic [2:0][6:0] opc, f7;
  logic [2:0][2:0] f3, fmt;
  logic [31:0] imm0, imm2;
  logic [63:0] imm1;
  int total = 0, bad = 0;
  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  idecode_stage #(.XLEN(32), .SKID(1)) u0 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
    .in_instr(in_instr), .out_valid(ov[0]), .out_ready(out_ready), .out_imm(imm0), .out_rs1(rs1[0]),
    .out_rs2(rs2[0]), .out_rd(rd[0]), .out_opcode(opc[0]), .out_funct3(f3[0]), .out_funct7(f7[0]),
    .out_fmt(fmt[0]), .out_illegal(ill[0]));
  idecode_stage #(.XLEN(64), .SKID(1)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
    .in_instr(in_instr), .out_valid(ov[1]), .out_ready(out_ready), .out_imm(imm1), .out_rs1(rs1[1]),
    .out_rs2(rs2[1]), .out_rd(rd[1]), .out_opcode(opc[1]), .out_funct3(f3[1]), .out_funct7(f7[1]),
    .out_fmt(fmt[1]), .out_illegal(ill[1]));
  idecode_stage #(.XLEN(32), .SKID(0)) u2 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
    .in_instr(in_instr), .out_valid(ov[2]), .out_ready(out_ready), .out_imm(imm2), .out_rs1(rs1[2]),
    .out_rs2(rs2[2]), .out_rd(rd[2]), .out_opcode(opc[2]), .out_funct3(f3[2]), .out_funct7(f7[2]),
    .out_fmt(fmt[2]), .out_illegal(ill[2]));

  task automatic cmp(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic longint sx32(input logic [31:0] v);
    longint r;
    r = $signed(v);
    return r;
  endfunction

  // Reference decode straight from the ISA rules, immediates built arithmetically.
  function automatic exp_t mdec(input logic [31:0] i, input int xlen);
    exp_t e;
    longint imm;
    int f3v, fm;
    bit ok;
    f3v = int'(i[14:12]);
    fm = 7; ok = 1'b1; imm = 0;
    case (i[6:0])
      7'h37, 7'h17: fm = 4;
      7'h6F: fm = 5;
      7'h0F, 7'h73: fm = 1;
      7'h67: begin fm = 1; ok = (f3v == 0); end
      7'h03: begin fm = 1; ok = (xlen == 64) ? (f3v != 7) : (f3v inside {0, 1, 2, 4, 5}); end
      7'h13: begin
        fm = 1;
        if (f3v == 1) ok = (i[31:26] == 6'h00) && (xlen == 64 || !i[25]);
        if (f3v == 5) ok = (i[31:26] == 6'h00 || i[31:26] == 6'h10) && (xlen == 64 || !i[25]);
      end
      7'h23: begin fm = 2; ok = (xlen == 64) ? (f3v < 4) : (f3v < 3); end
      7'h63: begin fm = 3; ok = !(f3v == 2 || f3v == 3); end
      7'h33: begin fm = 0; ok = (i[31:25] == 7'h00) || (i[31:25] == 7'h20 && (f3v == 0 || f3v == 5)); end
      default: ok = 1'b0;
    endcase
    if (!ok) fm = 7;
    case (fm)
      1: imm = sx32(i) >>> 20;
      2: imm = (sx32(i) >>> 25) * 32 + int'(i[11:7]);
      3: imm = (i[31] ? -64'sd4096 : 64'sd0) + 2048 * int'(i[7]) + 32 * int'(i[30:25]) + 2 * int'(i[11:8]);
      4: imm = sx32({i[31:12], 12'h000});
      5: imm = (i[31] ? -64'sd1048576 : 64'sd0) + 4096 * int'(i[19:12]) + 2048 * int'(i[20]) + 2 * int'(i[30:21]);
      default: imm = 0;
    endcase
    e.imm = (xlen == 32) ? {32'h0, imm[31:0]} : imm;
    e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
    e.opc = i[6:0]; e.f3 = i[14:12]; e.f7 = i[31:25];
    e.fmt = 3'(fm); e.ill = (fm == 7);
    return e;
  endfunction

  function automatic exp_t act(input int k);
    logic [63:0] im;
    im = (k == 0) ? {32'h0, imm0} : (k == 1) ? imm1 : {32'h0, imm2};
    return {im, rs1[k], rs2[k], rd[k], opc[k], f3[k], f7[k], fmt[k], ill[k]};
  endfunction

  function automatic int qsz(input int k);
    return (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
  endfunction
  function automatic exp_t qfront(input int k);
    return (k == 0) ? q0[0] : (k == 1) ? q1[0] : q2[0];
  endfunction
  task automatic qpop(input int k);
    if (k == 0) void'(q0.pop_front()); else if (k == 1) void'(q1.pop_front()); else void'(q2.pop_front());
  endtask
  task automatic qpush(input int k, input exp_t e);
    if (k == 0) q0.push_back(e); else if (k == 1) q1.push_back(e); else q2.push_back(e);
  endtask
  task automatic qclr(input int k);
    if (k == 0) q0.delete(); else if (k == 1) q1.delete(); else q2.delete();
  endtask

  // The stage holds exactly the queue contents; skid ready means fewer than two held.
  task automatic chk(input int k, input int xlen, input bit skid);
    exp_t a;
    a = act(k);
    if (rst) begin
      qclr(k);
      cmp($sformatf("rst_vld%0d", k), ov[k], 1'b0);
      cmp($sformatf("rst_data%0d", k), a, '0);
      cmp($sformatf("rst_rdy%0d", k), ir[k], 1'b1);
    end else begin
      cmp($sformatf("vld%0d", k), ov[k], qsz(k) > 0);
      cmp($sformatf("rdy%0d", k), ir[k], skid ? (qsz(k) < 2) : (qsz(k) == 0 || out_ready));
      if (ov[k] && qsz(k) > 0) begin
        cmp($sformatf("data%0d", k), a, qfront(k));
        if (out_ready) qpop(k);
      end
      if (in_valid && ir[k]) qpush(k, mdec(in_instr, xlen));
    end
  endtask

  always @(negedge clk) begin
    chk(0, 32, 1'b1);
    chk(1, 64, 1'b1);
    chk(2, 32, 1'b0);
  end

  task automatic sync;
    @(posedge clk); #1;
  endtask

  // Called at posedge+1; returns at posedge+1 right after u0 took the word, in_valid left high.
  task automatic put(input logic [31:0] w);
    int n;
    n = 0;
    in_valid = 1'b1; in_instr = w;
    @(negedge clk);
    while (!ir[0] && n < 40) begin @(negedge clk); n++; end
    if (!ir[0]) cmp("put_timeout", 1'b0, 1'b1);
    sync;
  endtask

  task automatic one(input logic [31:0] w);
    sync; put(w); in_valid = 1'b0;
    @(negedge clk);
  endtask

  logic [31:0] mix [18] = '{32'h00112623, 32'h008000EF, 32'hFFFFF517, 32'h40B50533, 32'h4030D093,
                            32'h4200D093, 32'h04009093, 32'h02000033, 32'h40001033, 32'h000010E7,
                            32'h0000C063, 32'h00002063, 32'h00113023, 32'h00004023, 32'h00000073,
                            32'h0FF0000F, 32'h00006083, 32'h0000007F};
  logic [31:0] pat = 32'b1011_0011_1000_1110_0111_1100_0110_1101;
  bit done;

  initial begin
    repeat (2) @(negedge clk);
    sync; rst = 1'b0;
    @(negedge clk);
    cmp("post_rst_vld", ov[0], 1'b0);
    cmp("post_rst_rdy", ir[0], 1'b1);

    one(32'h12345037);
    cmp("lui_vld", ov[0], 1'b1);
    cmp("lui_imm", imm0, 32'h12345000);
    cmp("lui_rd", rd[0], 5'd0);
    cmp("lui_fmt", fmt[0], 3'd4);
    cmp("lui_ill", ill[0], 1'b0);

    one(32'hFFF00093);
    cmp("addi_imm", imm0, 32'hFFFFFFFF);
    cmp("addi_rd", rd[0], 5'd1);
    cmp("addi_rs1", rs1[0], 5'd0);
    cmp("addi_f3", f3[0], 3'd0);
    cmp("addi_fmt", fmt[0], 3'd1);
    cmp("addi_imm64", imm1, 64'hFFFFFFFFFFFFFFFF);

    one(32'hFE000EE3);
    cmp("beq_imm", imm0, 32'hFFFFFFFC);
    cmp("beq_fmt", fmt[0], 3'd3);

    one(32'h00000000);
    cmp("zero_ill", ill[0], 1'b1);
    cmp("zero_fmt", fmt[0], 3'd7);
    cmp("zero_imm", imm0, 32'h0);

    one(32'h00003083);
    cmp("ld32_ill", ill[0], 1'b1);
    cmp("ld32_fmt", fmt[0], 3'd7);
    cmp("ld64_fmt", fmt[1], 3'd1);
    cmp("ld64_ill", ill[1], 1'b0);

    // Full-rate stream, then the same words under a stall pattern.
    sync;
    foreach (mix[j]) put(mix[j]);
    in_valid = 1'b0;
    done = 1'b0;
    fork
      begin
        foreach (mix[j]) put(mix[j]);
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        int c;
        c = 0;
        while (!done && c < 500) begin sync; out_ready = pat[c % 32]; c++; end
      end
    join
    out_ready = 1'b1;
    repeat (4) sync;

    // Skid fill: A and B land, C waits for in_ready.
    out_ready = 1'b0;
    put(32'h00100093);
    put(32'h00200113);
    in_instr = 32'h00300193;
    @(negedge clk);
    cmp("skid_full_rdy", ir[0], 1'b0);
    cmp("skid_head_rd", rd[0], 5'd1);
    repeat (3) sync;
    @(negedge clk);
    cmp("stall_rd", rd[0], 5'd1);
    sync; out_ready = 1'b1;
    @(negedge clk);
    cmp("rel_rdy_lag", ir[0], 1'b0);
    @(negedge clk);
    cmp("rel_rdy", ir[0], 1'b1);
    cmp("rel_rd_b", rd[0], 5'd2);
    sync; in_valid = 1'b0;
    @(negedge clk);
    cmp("rel_rd_c", rd[0], 5'd3);
    repeat (3) sync;

    // Async reset with both entries occupied.
    out_ready = 1'b0;
    put(32'h00100093);
    put(32'h00200113);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    cmp("async_rst_vld", ov[0], 1'b0);
    cmp("async_rst_vld_noskid", ov[2], 1'b0);
    @(negedge clk);
    @(posedge clk); #3 rst = 1'b0;
    @(negedge clk);
    cmp("after_rst_rdy", ir[0], 1'b1);
    cmp("after_rst_vld", ov[0], 1'b0);
    out_ready = 1'b1;
    one(32'h12345037);
    cmp("after_rst_imm", imm0, 32'h12345000);
    cmp("after_rst_fmt", fmt[0], 3'd4);
    repeat (3) sync;
    @(negedge clk);
    cmp("drained_vld", ov[0], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/idecode_stage.md
Name: idecode_stage

Overview:
- Registered RV32I/RV64I instruction-decode pipeline stage with valid/ready handshakes on both sides.
- Sits between the fetch stage and the register-file/execute stage.
- Generates sign-extended immediates for every base format (R/I/S/B/U/J), extracts the register and function fields, and flags illegal encodings.
- Optional 2-entry skid buffer keeps in_ready a pure register output.

Parameters:
- XLEN, 32, datapath width; 32 or 64. Sets immediate sign-extension width and RV64 load/store/shift legality.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single output register with combinational in_ready.

Ports:
- clk  input  1  clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  stage accepts an instruction this cycle
- in_instr  input  32  raw instruction word
- out_valid  output  1  decoded instruction is valid
- out_ready  input  1  downstream accepts
- out_imm  output  XLEN  sign-extended immediate; 0 for R-format or illegal
- out_rs1  output  5  instr[19:15]
- out_rs2  output  5  instr[24:20]
- out_rd  output  5  instr[11:7]
- out_opcode  output  7  instr[6:0]
- out_funct3  output  3  instr[14:12]
- out_funct7  output  7  instr[31:25]
- out_fmt  output  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal
- out_illegal  output  1  encoding not legal for XLEN

Behaviour:
- Reset (async): out_valid=0, skid entry empty, all data outputs 0. While rst is high, inputs are ignored. in_ready=1 after reset.
- Transfer occurs on valid&ready at a rising edge, on each side independently.
- Latency: instruction accepted in cycle N appears on outputs in cycle N+1.
- Throughput: 1 instruction per cycle when out_ready is held high.
- Outputs are stable while out_valid=1 and out_ready=0 (no change, no drop).
- SKID=0:
  - in_ready = !out_valid | out_ready.
  - The output register loads on input transfer.
  - out_valid clears when an output transfer occurs with no input transfer.
- SKID=1:
  - in_ready = !skid_full, registered.
  - Input transfer while output is stalled and full writes the skid entry; in_ready drops the next cycle.
  - On an output transfer, the skid entry (if full) moves to the output register and in_ready rises the next cycle.
  - Simultaneous input and output transfer with the skid entry empty: the output register loads the new instruction.
  - Order is always preserved; no duplication.
- Decode (combinational from the instruction word, registered into the stage):
  - U (LUI 0110111, AUIPC 0010111): imm = sext({instr[31:12], 12'b0}).
  - J (JAL 1101111): imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - I (JALR 1100111, LOAD 0000011, OP_IMM 0010011, MISC_MEM 0001111, SYSTEM 1110011): imm = sext(instr[31:20]).
  - S (STORE 0100011): imm = sext({instr[31:25], instr[11:7]}).
  - B (BRANCH 1100011): imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - R (OP 0110011): imm = 0.
- Illegal (out_fmt=7, out_imm=0, out_illegal=1; field outputs still pass through):
  - instr[1:0] != 11, or unlisted opcode.
  - JALR funct3 != 000.
  - BRANCH funct3 010 or 011.
  - LOAD funct3 111, or 011/110 when XLEN=32.
  - STORE funct3 1xx, or 011 when XLEN=32.
  - OP_IMM shifts:
    - funct3 001 requires instr[31:26]=000000.
    - funct3 101 requires instr[31:26] = 000000 or 010000.
    - When XLEN=32, instr[25] must also be 0.
  - OP: funct7 must be 0000000, or 0100000 only with funct3 000/101.
- Reset mid-operation: in-flight and skid entries are discarded; no output transfer completes after rst rises.

Test Plan:
- LUI 0x12345037, out_ready=1 → next cycle: out_valid=1, out_imm=0x12345000, rd=0, fmt=4, illegal=0.
- ADDI 0xFFF00093 → imm=0xFFFFFFFF, rd=1, rs1=0, funct3=0, fmt=1. With XLEN=64, imm=0xFFFFFFFFFFFFFFFF.
- BEQ 0xFE000EE3 → imm=0xFFFFFFFC, fmt=3. Word 0x00000000 → illegal=1, fmt=7, imm=0.
- LD 0x00003083: XLEN=32 → illegal=1; XLEN=64 → fmt=1, illegal=0.
- SKID=1, out_ready=0, push A, B, C back-to-back:
  - A and B are accepted; in_ready=0 from the cycle after B.
  - Release out_ready: A, B, C are emitted in order, with C accepted once in_ready=1.
  - out_* stays stable while stalled.
- Assert rst while both entries are full → out_valid=0 immediately (async); in_ready=1 after release; the next instruction decodes normally.
